// File: rtl/cordic_vectoring_if.sv
// rtl/cordic_vectoring_if.sv - sample/result handshake bundle for the CORDIC vectoring engine
interface cordic_vectoring_if #(
  parameter int XY_W    = 16,
  parameter int ANGLE_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [XY_W-1:0]    x_in;
  logic signed [XY_W-1:0]    y_in;
  logic                      out_valid;
  logic                      out_ready;
  logic        [XY_W+1:0]    magnitude;
  logic        [ANGLE_W-1:0] phase;
  logic                      busy;

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, magnitude, phase, busy
  );

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, magnitude, phase, busy
  );
endinterface

// File: rtl/cordic_vectoring.sv
// rtl/cordic_vectoring.sv - iterative CORDIC vectoring engine: (x,y) -> magnitude and atan2 phase
// One micro-rotation per clock on a shared datapath; results held until out_ready.
module cordic_vectoring #(
  parameter int XY_W      = 16,
  parameter int ANGLE_W   = 32,
  parameter int ITER      = 16,
  parameter int GUARD     = 3,
  parameter int GAIN_COMP = 0
) (
  input  logic               clk,
  input  logic               rst,
  cordic_vectoring_if.slave  s_if
);
  localparam int IW         = XY_W + GUARD + 2;
  localparam int CW         = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int MW         = XY_W + 2;
  localparam int PW         = IW + 17;
  localparam int KINV_Q15   = 19899;
  localparam int KINV_SHIFT = 15;
  localparam int SH_L       = (ANGLE_W > 32) ? ANGLE_W - 32 : 0;
  localparam int SH_R       = (ANGLE_W < 32) ? 32 - ANGLE_W : 0;
  localparam logic signed [PW-1:0] KINV_EXT = PW'(KINV_Q15);

  // atan(2^-i) as a 32-bit binary angle (2^32 = 2*pi), rescaled to ANGLE_W
  localparam logic [31:0] ATAN32 [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

  function automatic logic [ANGLE_W-1:0] atan_of(input logic [CW-1:0] i);
    logic [4:0] idx;
    idx = 5'(i);
    return ANGLE_W'(({32'd0, ATAN32[idx]} << SH_L) >> SH_R);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic                      w_in_ready;
  logic                      w_out_valid;
  logic                      w_busy;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_x_neg;
  logic                      w_zero_in;

  logic signed [IW-1:0]      r_x;
  logic signed [IW-1:0]      r_y;
  logic        [ANGLE_W-1:0] r_z;
  logic        [CW-1:0]      r_cnt;
  logic                      r_zero;
  logic        [MW-1:0]      r_mag;
  logic        [ANGLE_W-1:0] r_phase;

  logic signed [IW-1:0]      w_x_ext;
  logic signed [IW-1:0]      w_y_ext;
  logic signed [IW-1:0]      w_x_ld;
  logic signed [IW-1:0]      w_y_ld;
  logic        [ANGLE_W-1:0] w_z_ld;
  logic signed [IW-1:0]      w_x_sh;
  logic signed [IW-1:0]      w_y_sh;
  logic signed [IW-1:0]      w_x_nxt;
  logic signed [IW-1:0]      w_y_nxt;
  logic        [ANGLE_W-1:0] w_z_nxt;
  logic        [ANGLE_W-1:0] w_atan;
  logic signed [PW-1:0]      w_x_wide;
  logic signed [PW-1:0]      w_prod;
  logic signed [PW-1:0]      w_scaled;
  logic signed [PW-1:0]      w_floor;
  logic        [MW-1:0]      w_mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_ITER;
      S_ITER: if (w_last) w_state_nxt = S_DONE;
      S_DONE: if (s_if.out_ready) w_state_nxt = s_if.in_valid ? S_ITER : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && s_if.out_ready);
    w_out_valid = (r_state == S_DONE);
    w_busy      = (r_state == S_ITER) || (r_state == S_DONE);
  end

  assign w_accept = s_if.in_valid && w_in_ready;
  assign w_last   = (r_cnt == CW'(ITER - 1));

  // Pre-fold the left half-plane onto the right one so the iterations converge.
  always_comb begin
    w_x_ext   = {{(IW-XY_W){s_if.x_in[XY_W-1]}}, s_if.x_in} <<< GUARD;
    w_y_ext   = {{(IW-XY_W){s_if.y_in[XY_W-1]}}, s_if.y_in} <<< GUARD;
    w_x_neg   = s_if.x_in[XY_W-1];
    w_zero_in = (s_if.x_in == '0) && (s_if.y_in == '0);
    w_x_ld    = w_x_neg ? -w_x_ext : w_x_ext;
    w_y_ld    = w_x_neg ? -w_y_ext : w_y_ext;
    w_z_ld    = w_x_neg ? {1'b1, {(ANGLE_W-1){1'b0}}} : '0;
  end

  always_comb begin
    w_x_sh = r_x >>> r_cnt;
    w_y_sh = r_y >>> r_cnt;
    w_atan = atan_of(r_cnt);
    if (!r_y[IW-1]) begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end else begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end
  end

  // Magnitude taken from the final micro-rotation's x; saturates rather than wraps.
  always_comb begin
    w_x_wide = {{(PW-IW){w_x_nxt[IW-1]}}, w_x_nxt};
    w_prod   = w_x_wide * KINV_EXT;
    w_scaled = (GAIN_COMP != 0) ? (w_prod >>> KINV_SHIFT) : w_x_wide;
    w_floor  = w_scaled >>> GUARD;
    if (w_floor[PW-1]) begin
      w_mag = '0;
    end else if (|w_floor[PW-2:MW]) begin
      w_mag = '1;
    end else begin
      w_mag = w_floor[MW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_cnt   <= '0;
      r_zero  <= 1'b0;
      r_mag   <= '0;
      r_phase <= '0;
    end else begin
      if (w_accept) begin
        r_x    <= w_x_ld;
        r_y    <= w_y_ld;
        r_z    <= w_z_ld;
        r_cnt  <= '0;
        r_zero <= w_zero_in;
      end else if (r_state == S_ITER) begin
        r_x   <= w_x_nxt;
        r_y   <= w_y_nxt;
        r_z   <= w_z_nxt;
        r_cnt <= r_cnt + CW'(1);
      end
      if ((r_state == S_ITER) && w_last) begin
        r_mag   <= r_zero ? '0 : w_mag;
        r_phase <= r_zero ? '0 : w_z_nxt;
      end
    end
  end

  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = w_out_valid;
  assign s_if.busy      = w_busy;
  assign s_if.magnitude = r_mag;
  assign s_if.phase     = r_phase;
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb/tb_cordic_vectoring.sv - self-checking bench for cordic_vectoring
module tb_cordic_vectoring;
  localparam int  XY_W     = 16;
  localparam int  ANGLE_W  = 32;
  localparam int  ITER     = 16;
  localparam int  GUARD    = 3;
  localparam int  KINV_Q15 = 19899;
  localparam real PI       = 3.14159265358979;
  localparam int  PH_TOL   = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_vectoring_if #(.XY_W(XY_W), .ANGLE_W(ANGLE_W)) if_c ();
  cordic_vectoring_if #(.XY_W(XY_W), .ANGLE_W(ANGLE_W)) if_n ();

  assign if_n.in_valid  = if_c.in_valid;
  assign if_n.x_in      = if_c.x_in;
  assign if_n.y_in      = if_c.y_in;
  assign if_n.out_ready = if_c.out_ready;

  cordic_vectoring #(.XY_W(XY_W), .ANGLE_W(ANGLE_W), .ITER(ITER), .GUARD(GUARD), .GAIN_COMP(1))
    u_dut_c (.clk(clk), .rst(rst), .s_if(if_c));
  cordic_vectoring #(.XY_W(XY_W), .ANGLE_W(ANGLE_W), .ITER(ITER), .GUARD(GUARD), .GAIN_COMP(0))
    u_dut_n (.clk(clk), .rst(rst), .s_if(if_n));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          x;
    int          y;
    logic [31:0] ph;
    int          ph_tol;
    int          mag;
    int          mag_tol;
    bit          on_n;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input longint got, input longint exp, input longint tol);
    longint d;
    d = got - exp;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (+-%0d)", name, got, exp, tol);
    end
  endtask

  task automatic chk_ph(input string name, input logic [31:0] got, input logic [31:0] exp, input longint tol);
    logic [31:0] d;
    d = got - exp;
    if (d[31]) d = -d;
    n_cmp++;
    if (longint'(d) > tol) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (+-%0d)", name, got, exp, tol);
    end
  endtask

  function automatic real k_gain();
    real k, p;
    k = 1.0;
    p = 1.0;
    for (int i = 0; i < ITER; i++) begin
      k = k * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    return k;
  endfunction

  function automatic int ref_mag(input int x, input int y, input bit comp);
    real m;
    m = $sqrt(real'(x) * real'(x) + real'(y) * real'(y)) * k_gain();
    if (comp) m = m * real'(KINV_Q15) / 32768.0;
    return int'($floor(m));
  endfunction

  function automatic logic [31:0] ref_phase(input int x, input int y);
    real    a;
    longint v;
    if (x == 0 && y == 0) return 32'h0;
    a = $atan2(real'(y), real'(x)) / (2.0 * PI) * 4294967296.0;
    if (a < 0.0) a = a + 4294967296.0;
    v = longint'(a);
    return v[31:0];
  endfunction

  task automatic run(input int x, input int y,
                     output logic [17:0] mc, output logic [17:0] mn,
                     output logic [31:0] pc, output logic [31:0] pn, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!if_c.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL in_ready_wait: got 0, want 1 within 100 cycles");
    end
    if_c.x_in     = 16'(x);
    if_c.y_in     = 16'(y);
    if_c.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if_c.in_valid = 1'b0;
    lat = 0;
    while (!if_c.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    mc = if_c.magnitude;
    mn = if_n.magnitude;
    pc = if_c.phase;
    pn = if_n.phase;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [17:0] mc, mn, m0;
    logic [31:0] pc, pn;
    int          lat, x, y, tries, last_ov;
    int          acc_edges[$];

    tbl[0] = '{16384,       0, 32'h0000_0000, PH_TOL, 16384, 4, 1'b0};
    tbl[1] = '{    0,   16384, 32'h4000_0000, PH_TOL, 16384, 4, 1'b0};
    tbl[2] = '{    0,  -16384, 32'hC000_0000, PH_TOL, 16384, 4, 1'b0};
    tbl[3] = '{-16384,      0, 32'h8000_0000, PH_TOL, 16384, 4, 1'b0};
    tbl[4] = '{-32768, -32768, 32'hA000_0000, PH_TOL, 76315, 8, 1'b1};
    tbl[5] = '{-32768,      0, 32'h8000_0000, PH_TOL, 32768, 4, 1'b0};
    tbl[6] = '{    0,       0, 32'h0000_0000, 0,          0, 0, 1'b0};

    if_c.in_valid  = 1'b0;
    if_c.x_in      = '0;
    if_c.y_in      = '0;
    if_c.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", if_c.out_valid, 0, 0);
    chk("reset_busy", if_c.busy, 0, 0);
    chk("reset_magnitude", if_c.magnitude, 0, 0);
    chk("reset_phase", if_c.phase, 0, 0);
    chk("reset_in_ready", if_c.in_ready, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].x, tbl[i].y, mc, mn, pc, pn, lat);
      chk($sformatf("tbl%0d_latency_cycles", i), lat + 1, ITER + 1, 0);
      chk_ph($sformatf("tbl%0d_phase", i), pc, tbl[i].ph, tbl[i].ph_tol);
      if (tbl[i].on_n) chk($sformatf("tbl%0d_mag_nocomp", i), mn, tbl[i].mag, tbl[i].mag_tol);
      else             chk($sformatf("tbl%0d_mag_comp", i), mc, tbl[i].mag, tbl[i].mag_tol);
    end

    for (int i = 0; i < 25; i++) begin
      tries = 0;
      do begin
        x = int'($urandom_range(65535)) - 32768;
        y = int'($urandom_range(65535)) - 32768;
        tries++;
      end while ((x * x + y * y < 8192 * 8192) && tries < 50);
      run(x, y, mc, mn, pc, pn, lat);
      chk($sformatf("rnd%0d_mag_comp(%0d,%0d)", i, x, y), mc, ref_mag(x, y, 1'b1), 4);
      chk($sformatf("rnd%0d_mag_nocomp(%0d,%0d)", i, x, y), mn, ref_mag(x, y, 1'b0), 8);
      chk_ph($sformatf("rnd%0d_phase_comp(%0d,%0d)", i, x, y), pc, ref_phase(x, y), PH_TOL);
      chk_ph($sformatf("rnd%0d_phase_nocomp(%0d,%0d)", i, x, y), pn, ref_phase(x, y), PH_TOL);
    end

    // Stall in DONE: results frozen, new requests refused, then back-to-back accept.
    @(negedge clk);
    if_c.out_ready = 1'b0;
    if_c.x_in      = 16'sd12000;
    if_c.y_in      = 16'sd5000;
    if_c.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    if_c.in_valid = 1'b0;
    lat = 0;
    while (!if_c.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_latency_cycles", lat + 1, ITER + 1, 0);
    m0 = if_c.magnitude;
    chk("stall_mag", m0, ref_mag(12000, 5000, 1'b1), 4);
    chk_ph("stall_phase", if_c.phase, ref_phase(12000, 5000), PH_TOL);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if_c.in_valid = c[0];
      if_c.x_in     = 16'($urandom);
      if_c.y_in     = 16'($urandom);
      #1;
      chk("stall_in_ready", if_c.in_ready, 0, 0);
      chk("stall_out_valid", if_c.out_valid, 1, 0);
      chk("stall_mag_held", if_c.magnitude, ref_mag(12000, 5000, 1'b1), 4);
      chk_ph("stall_phase_held", if_c.phase, ref_phase(12000, 5000), PH_TOL);
    end
    @(negedge clk);
    if_c.out_ready = 1'b1;
    if_c.in_valid  = 1'b1;
    if_c.x_in      = -16'sd7000;
    if_c.y_in      = 16'sd9000;
    #1;
    chk("b2b_in_ready", if_c.in_ready, 1, 0);
    @(posedge clk);
    #1;
    if_c.in_valid = 1'b0;
    chk("b2b_out_valid_dropped", if_c.out_valid, 0, 0);
    chk("b2b_busy", if_c.busy, 1, 0);
    lat = 0;
    while (!if_c.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("b2b_latency_cycles", lat + 1, ITER + 1, 0);
    chk("b2b_mag", if_c.magnitude, ref_mag(-7000, 9000, 1'b1), 4);
    chk_ph("b2b_phase", if_c.phase, ref_phase(-7000, 9000), PH_TOL);
    @(posedge clk);
    #1;

    // Continuous valid/ready: one accept every ITER+1 cycles.
    @(negedge clk);
    if_c.x_in     = 16'sd3000;
    if_c.y_in     = -16'sd20000;
    if_c.in_valid = 1'b1;
    for (int e = 0; e < 3 * (ITER + 1) + 1; e++) begin
      if (if_c.in_ready) acc_edges.push_back(e);
      @(posedge clk);
      #1;
    end
    if_c.in_valid = 1'b0;
    chk("thru_accept_count", acc_edges.size(), 4, 0);
    for (int k = 1; k < acc_edges.size(); k++)
      chk($sformatf("thru_gap%0d", k), acc_edges[k] - acc_edges[k-1], ITER + 1, 0);
    lat = 0;
    while (!if_c.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("thru_last_mag", if_c.magnitude, ref_mag(3000, -20000, 1'b1), 4);
    @(posedge clk);
    #1;

    // Reset in the middle of an iteration run.
    @(negedge clk);
    if_c.x_in     = 16'sd10000;
    if_c.y_in     = 16'sd10000;
    if_c.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if_c.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", if_c.out_valid, 0, 0);
    chk("midrst_busy", if_c.busy, 0, 0);
    chk("midrst_magnitude", if_c.magnitude, 0, 0);
    chk("midrst_phase", if_c.phase, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    last_ov = 0;
    for (int c = 0; c < 2 * ITER; c++) begin
      @(posedge clk);
      #1;
      if (if_c.out_valid) last_ov = 1;
    end
    chk("midrst_no_result", last_ov, 0, 0);
    run(0, 0, mc, mn, pc, pn, lat);
    chk("postrst_zero_latency_cycles", lat + 1, ITER + 1, 0);
    chk("postrst_zero_mag", mc, 0, 0);
    chk("postrst_zero_mag_nocomp", mn, 0, 0);
    chk_ph("postrst_zero_phase", pc, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
